// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: I-side, D-side and memory-side cacheline port signals
interface mem_port_arbiter_if #(
    parameter int S_LINE = 256,
    parameter int S_ADDR = 32
);
    logic              i_pmem_read;
    logic [S_ADDR-1:0] i_pmem_address;
    logic [S_LINE-1:0] i_pmem_rdata;
    logic              i_pmem_resp;
    logic              d_pmem_read;
    logic              d_pmem_write;
    logic [S_ADDR-1:0] d_pmem_address;
    logic [S_LINE-1:0] d_pmem_wdata;
    logic [S_LINE-1:0] d_pmem_rdata;
    logic              d_pmem_resp;
    logic              pmem_read;
    logic              pmem_write;
    logic [S_ADDR-1:0] pmem_address;
    logic [S_LINE-1:0] pmem_wdata;
    logic [S_LINE-1:0] pmem_rdata;
    logic              pmem_resp;

    modport slave (
        input  i_pmem_read, i_pmem_address, d_pmem_read, d_pmem_write,
               d_pmem_address, d_pmem_wdata, pmem_rdata, pmem_resp,
        output i_pmem_rdata, i_pmem_resp, d_pmem_rdata, d_pmem_resp,
               pmem_read, pmem_write, pmem_address, pmem_wdata
    );

    modport master (
        output i_pmem_read, i_pmem_address, d_pmem_read, d_pmem_write,
               d_pmem_address, d_pmem_wdata, pmem_rdata, pmem_resp,
        input  i_pmem_rdata, i_pmem_resp, d_pmem_rdata, d_pmem_resp,
               pmem_read, pmem_write, pmem_address, pmem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serializes I-cache and D-cache line transactions onto one memory port
module mem_port_arbiter (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.slave   bus,
    output logic [31:0]         i_grants,
    output logic [31:0]         d_grants
);
    typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, RECOVER} state_t;

    state_t state, state_next;
    logic   last_d;
    logic   i_req, d_req;

    assign i_req            = bus.i_pmem_read;
    assign d_req            = bus.d_pmem_read | bus.d_pmem_write;
    assign bus.i_pmem_rdata = bus.pmem_rdata;
    assign bus.d_pmem_rdata = bus.pmem_rdata;

    // state register, fairness history and completed-grant counters
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            last_d   <= 1'b0;
            i_grants <= 32'd0;
            d_grants <= 32'd0;
        end else begin
            state <= state_next;
            if (state == GRANT_I && bus.pmem_resp) begin
                last_d   <= 1'b0;
                i_grants <= i_grants + 32'd1;
            end
            if (state == GRANT_D && bus.pmem_resp) begin
                last_d   <= 1'b1;
                d_grants <= d_grants + 32'd1;
            end
        end
    end

    // next state plus memory-port mux and response routing for the owning side
    always_comb begin
        state_next       = state;
        bus.pmem_read    = 1'b0;
        bus.pmem_write   = 1'b0;
        bus.pmem_address = '0;
        bus.pmem_wdata   = '0;
        bus.i_pmem_resp  = 1'b0;
        bus.d_pmem_resp  = 1'b0;
        case (state)
            IDLE: state_next = (i_req && d_req) ? (last_d ? GRANT_I : GRANT_D) :
                               i_req ? GRANT_I : d_req ? GRANT_D : IDLE;
            GRANT_I: begin
                bus.pmem_read    = bus.i_pmem_read;
                bus.pmem_address = bus.i_pmem_address;
                bus.i_pmem_resp  = bus.pmem_resp;
                state_next       = bus.pmem_resp ? RECOVER : GRANT_I;
            end
            GRANT_D: begin
                bus.pmem_read    = bus.d_pmem_read;
                bus.pmem_write   = bus.d_pmem_write;
                bus.pmem_address = bus.d_pmem_address;
                bus.pmem_wdata   = bus.d_pmem_wdata;
                bus.d_pmem_resp  = bus.pmem_resp;
                state_next       = bus.pmem_resp ? RECOVER : GRANT_D;
            end
            default: state_next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed cycle-by-cycle vectors plus an alternation sequence
module tb_mem_port_arbiter;
    localparam logic [255:0] Z = '0;
    localparam logic [255:0] A = {32{8'hA5}};
    localparam logic [255:0] B = {32{8'h5A}};
    localparam logic [255:0] W = {4{64'h0123456789ABCDEF}};

    typedef struct {
        logic         rst;
        logic         ir;
        logic [31:0]  ia;
        logic         dr;
        logic         dw;
        logic [31:0]  da;
        logic [255:0] wd;
        logic         rsp;
        logic [255:0] rd;
        int           n;
        logic         e_pr;
        logic         e_pw;
        logic [31:0]  e_pa;
        logic [255:0] e_pwd;
        logic         e_ir;
        logic         e_dr;
        logic [31:0]  e_ig;
        logic [31:0]  e_dg;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] i_grants, d_grants;
    int          total = 0;
    int          passed = 0;
    vec_t        tbl[$];

    mem_port_arbiter_if #(.S_LINE(256), .S_ADDR(32)) bus ();

    mem_port_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .i_grants (i_grants),
        .d_grants (d_grants)
    );

    always #5 clk = ~clk;

    function automatic vec_t v(
        input logic rst_i, input logic ir, input logic [31:0] ia,
        input logic dr, input logic dw, input logic [31:0] da, input logic [255:0] wd,
        input logic rsp, input logic [255:0] rd, input int n,
        input logic e_pr, input logic e_pw, input logic [31:0] e_pa, input logic [255:0] e_pwd,
        input logic e_ir, input logic e_dr, input logic [31:0] e_ig, input logic [31:0] e_dg);
        vec_t r;
        r.rst = rst_i; r.ir = ir; r.ia = ia; r.dr = dr; r.dw = dw; r.da = da; r.wd = wd;
        r.rsp = rsp; r.rd = rd; r.n = n;
        r.e_pr = e_pr; r.e_pw = e_pw; r.e_pa = e_pa; r.e_pwd = e_pwd;
        r.e_ir = e_ir; r.e_dr = e_dr; r.e_ig = e_ig; r.e_dg = e_dg;
        return r;
    endfunction

    task automatic chk(input string name, input int row, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
        else passed++;
    endtask

    // apply each row for n cycles: drive after posedge, compare at negedge
    task automatic run_tbl(input string tag);
        for (int r = 0; r < tbl.size(); r++) begin
            for (int k = 0; k < tbl[r].n; k++) begin
                rst                = tbl[r].rst;
                bus.i_pmem_read    = tbl[r].ir;
                bus.i_pmem_address = tbl[r].ia;
                bus.d_pmem_read    = tbl[r].dr;
                bus.d_pmem_write   = tbl[r].dw;
                bus.d_pmem_address = tbl[r].da;
                bus.d_pmem_wdata   = tbl[r].wd;
                bus.pmem_resp      = tbl[r].rsp;
                bus.pmem_rdata     = tbl[r].rd;
                @(negedge clk);
                chk({tag, "_pmem_read"}, r, 256'(bus.pmem_read), 256'(tbl[r].e_pr));
                chk({tag, "_pmem_write"}, r, 256'(bus.pmem_write), 256'(tbl[r].e_pw));
                chk({tag, "_pmem_address"}, r, 256'(bus.pmem_address), 256'(tbl[r].e_pa));
                chk({tag, "_pmem_wdata"}, r, bus.pmem_wdata, tbl[r].e_pwd);
                chk({tag, "_i_resp"}, r, 256'(bus.i_pmem_resp), 256'(tbl[r].e_ir));
                chk({tag, "_d_resp"}, r, 256'(bus.d_pmem_resp), 256'(tbl[r].e_dr));
                chk({tag, "_i_grants"}, r, 256'(i_grants), 256'(tbl[r].e_ig));
                chk({tag, "_d_grants"}, r, 256'(d_grants), 256'(tbl[r].e_dg));
                if (tbl[r].e_ir) chk({tag, "_i_rdata"}, r, bus.i_pmem_rdata, tbl[r].rd);
                if (tbl[r].e_dr) chk({tag, "_d_rdata"}, r, bus.d_pmem_rdata, tbl[r].rd);
                @(posedge clk);
                #1;
            end
        end
        tbl.delete();
    endtask

    initial begin
        int busy, got, cyc;
        logic exp_d[4];
        rst = 1'b1;
        bus.i_pmem_read = 1'b0; bus.i_pmem_address = '0;
        bus.d_pmem_read = 1'b0; bus.d_pmem_write = 1'b0;
        bus.d_pmem_address = '0; bus.d_pmem_wdata = '0;
        bus.pmem_resp = 1'b0; bus.pmem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        // idle after reset, single I read, reset, D-first tie then I
        tbl.push_back(v(0,0,0,0,0,0,Z,0,Z,10, 0,0,0,Z,0,0,0,0));
        tbl.push_back(v(0,1,'h60,0,0,0,Z,0,Z,1, 0,0,0,Z,0,0,0,0));
        tbl.push_back(v(0,1,'h60,0,0,0,Z,0,Z,4, 1,0,'h60,Z,0,0,0,0));
        tbl.push_back(v(0,1,'h60,0,0,0,Z,1,A,1, 1,0,'h60,Z,1,0,0,0));
        tbl.push_back(v(0,0,0,0,0,0,Z,0,Z,1, 0,0,0,Z,0,0,1,0));
        tbl.push_back(v(0,0,0,0,0,0,Z,0,Z,1, 0,0,0,Z,0,0,1,0));
        tbl.push_back(v(1,0,0,0,0,0,Z,0,Z,1, 0,0,0,Z,0,0,1,0));
        tbl.push_back(v(0,1,'h100,1,0,'h200,Z,0,Z,1, 0,0,0,Z,0,0,0,0));
        tbl.push_back(v(0,1,'h100,1,0,'h200,Z,0,Z,2, 1,0,'h200,Z,0,0,0,0));
        tbl.push_back(v(0,1,'h100,1,0,'h200,Z,1,A,1, 1,0,'h200,Z,0,1,0,0));
        tbl.push_back(v(0,1,'h100,0,0,0,Z,0,Z,1, 0,0,0,Z,0,0,0,1));
        tbl.push_back(v(0,1,'h100,0,0,0,Z,0,Z,1, 0,0,0,Z,0,0,0,1));
        tbl.push_back(v(0,1,'h100,0,0,0,Z,0,Z,1, 1,0,'h100,Z,0,0,0,1));
        tbl.push_back(v(0,1,'h100,0,0,0,Z,1,B,1, 1,0,'h100,Z,1,0,0,1));
        tbl.push_back(v(0,0,0,0,0,0,Z,0,Z,1, 0,0,0,Z,0,0,1,1));
        tbl.push_back(v(0,0,0,0,0,0,Z,0,Z,1, 0,0,0,Z,0,0,1,1));
        run_tbl("p1");

        // both sides request continuously: expect D, I, D, I
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.i_pmem_read = 1'b1; bus.i_pmem_address = 32'h300;
        bus.d_pmem_read = 1'b1; bus.d_pmem_address = 32'h400;
        bus.pmem_rdata = A;
        exp_d[0] = 1'b1; exp_d[1] = 1'b0; exp_d[2] = 1'b1; exp_d[3] = 1'b0;
        busy = 0; got = 0; cyc = 0;
        while (got < 4 && cyc < 200) begin
            if (bus.pmem_read) busy++;
            bus.pmem_resp = (busy == 3);
            @(negedge clk);
            if (bus.i_pmem_resp || bus.d_pmem_resp) begin
                chk("alt_owner_is_d", got, 256'(bus.d_pmem_resp), 256'(exp_d[got]));
                chk("alt_both_resp", got, 256'(bus.i_pmem_resp & bus.d_pmem_resp), 256'(0));
                chk("alt_address", got, 256'(bus.pmem_address), exp_d[got] ? 256'('h400) : 256'('h300));
                got++;
                busy = 0;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("alt_completed", 0, 256'(got), 256'(4));
        bus.pmem_resp = 1'b0;
        bus.i_pmem_read = 1'b0; bus.i_pmem_address = '0;
        bus.d_pmem_read = 1'b0; bus.d_pmem_address = '0;
        chk("alt_i_grants", 0, 256'(i_grants), 256'(2));
        chk("alt_d_grants", 0, 256'(d_grants), 256'(2));

        // writeback with I held off, stray resp in RECOVER, reset mid GRANT_I
        tbl.push_back(v(1,0,0,0,0,0,Z,0,Z,1, 0,0,0,Z,0,0,2,2));
        tbl.push_back(v(0,0,0,0,1,'h1000,W,0,Z,1, 0,0,0,Z,0,0,0,0));
        tbl.push_back(v(0,0,0,0,1,'h1000,W,0,Z,1, 0,1,'h1000,W,0,0,0,0));
        tbl.push_back(v(0,1,'h60,0,1,'h1000,W,0,Z,2, 0,1,'h1000,W,0,0,0,0));
        tbl.push_back(v(0,1,'h60,0,1,'h1000,W,1,A,1, 0,1,'h1000,W,0,1,0,0));
        tbl.push_back(v(0,1,'h60,0,0,0,Z,1,A,1, 0,0,0,Z,0,0,0,1));
        tbl.push_back(v(0,1,'h60,0,0,0,Z,0,Z,1, 0,0,0,Z,0,0,0,1));
        tbl.push_back(v(0,1,'h60,0,0,0,Z,0,Z,1, 1,0,'h60,Z,0,0,0,1));
        tbl.push_back(v(1,1,'h60,0,0,0,Z,0,Z,1, 1,0,'h60,Z,0,0,0,1));
        tbl.push_back(v(0,0,0,0,0,0,Z,1,A,1, 0,0,0,Z,0,0,0,0));
        tbl.push_back(v(0,0,0,0,0,0,Z,0,Z,1, 0,0,0,Z,0,0,0,0));
        run_tbl("p2");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
